pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control block for the 5-stage core. It merges per-stage stall requests from fetch, decode, execute and memory into the 6-bit `stall` vector that freezes the PC and pipeline registers. It also sequences a multi-cycle flush/redirect on exception or redirect requests, and counts stalled cycles for performance monitoring. It sits beside the stage chain and drives the enables of the PC register and of every inter-stage register.

## Interface
Parameters:
- `FLUSH_LEN`, 2 — cycles `flush_o` stays asserted per flush (1..15).
- `WDT_LIMIT`, 255 — consecutive stalled cycles that trip the watchdog (1..255).
- `WDT_VECTOR`, 32'h0000_0180 — redirect PC used on a watchdog flush.

Ports:
- `clk` in 1 — core clock, rising edge.
- `rst` in 1 — synchronous, active-high (`RstEnable` = 1'b1).
- `stallreq_if_i` in 1 — fetch not ready.
- `stallreq_id_i` in 1 — decode load-use hazard.
- `stallreq_ex_i` in 1 — multi-cycle execute op busy.
- `stallreq_mem_i` in 1 — data memory not ready.
- `flush_req_i` in 1 — exception/redirect request, single-cycle pulse or level.
- `new_pc_i` in 32 — redirect target, valid with `flush_req_i`.
- `stall_o` out 6 — bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- `flush_o` out 1 — clear all pipeline registers, load `new_pc_o`.
- `new_pc_o` out 32 — registered redirect target.
- `state_o` out 2 — 00 RUN, 01 STALL, 10 FLUSH.
- `stall_cycles_o` out 32 — free-running count of cycles with `stall_o` != 0.
- `wdt_o` out 1 — watchdog trip pulse.

## Operation
- Stall vector is combinational, decided by the highest-priority (latest-stage) request:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
- In FLUSH, `stall_o` is forced to 0.
- FSM, registered:
  - RUN → STALL when any request is active and `flush_req_i`=0.
  - STALL → RUN when no request is active.
  - RUN/STALL/FLUSH → FLUSH on `flush_req_i`=1 (flush beats stall). Entering FLUSH loads `new_pc_o` ← `new_pc_i` and flush counter ← `FLUSH_LEN`-1.
  - FLUSH: counter decrements each cycle. At 0 the FSM goes to STALL if any request is active, else RUN.
  - `flush_req_i` during FLUSH restarts the counter and recaptures `new_pc_o`.
- `flush_o` = (state == FLUSH).
- `stall_cycles_o` increments each cycle `stall_o` != 0 and wraps at 2^32-1 → 0.
- Reset values: state RUN, `stall_o` 0, `flush_o` 0, `new_pc_o` 0, `stall_cycles_o` 0, `wdt_o` 0, flush counter 0. Reset asserted mid-FLUSH or mid-STALL returns to RUN on the next edge.

## Timing
- `stall_o` has zero latency from `stallreq_*_i`, in the same cycle (RUN/STALL only).
- `flush_o` rises on the edge after `flush_req_i` is sampled high and stays high exactly `FLUSH_LEN` cycles absent new requests.
- A stall request in the same cycle as `flush_req_i`: `stall_o` honors it that cycle; `stall_o` is 0 from the next cycle for the FLUSH duration.
- `stall_cycles_o` updates one cycle after the counted stall cycle.

## Configuration
- `STALL_WDT_EN` defined:
  - An 8-bit saturating counter counts consecutive cycles with `stall_o` != 0 and clears on any non-stalled cycle or on FLUSH.
  - When it reaches `WDT_LIMIT`, `wdt_o` pulses for one cycle. On that same edge the FSM enters FLUSH with `new_pc_o` ← `WDT_VECTOR`, and the counter clears.
  - A simultaneous `flush_req_i` takes precedence: `new_pc_i` is loaded and `wdt_o` still pulses.
- `STALL_WDT_EN` undefined: no watchdog counter exists, `wdt_o` is tied to 0, and `WDT_LIMIT`/`WDT_VECTOR` are unused.

## Test plan
- Reset, then idle → `stall_o`=0, `state_o`=00, `flush_o`=0, `stall_cycles_o`=0.
- Assert `stallreq_id_i` and `stallreq_mem_i` together for 3 cycles → `stall_o`=6'b011111 those cycles, `state_o`=01, `stall_cycles_o`=3 afterward, RUN one cycle after release.
- `flush_req_i` pulse with `new_pc_i`=32'h0000_2000 while `stallreq_ex_i`=1, `FLUSH_LEN`=2:
  - `stall_o`=6'b001111 in the request cycle.
  - Next 2 cycles: `flush_o`=1, `stall_o`=0, `new_pc_o`=32'h0000_2000.
  - Then STALL.
- Second `flush_req_i` (32'h0000_3000) during the first FLUSH cycle → `flush_o` held for 2 more cycles, `new_pc_o`=32'h0000_3000.
- With `STALL_WDT_EN`, `WDT_LIMIT`=4, `stallreq_if_i` held high → `wdt_o` pulses on the 4th stalled cycle's edge, then `flush_o`=1 and `new_pc_o`=32'h0000_0180.
- `rst` asserted during FLUSH → next cycle `state_o`=00, `flush_o`=0, `new_pc_o`=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the 5-stage core.
// Merges per-stage stall requests into the stall enable vector and sequences
// multi-cycle flushes. It also counts stalled cycles for performance monitoring.
// Optional stall watchdog: define STALL_WDT_EN to build it. When the macro is
// undefined, wdt_o is tied low and WDT_LIMIT/WDT_VECTOR have no effect.
// state_o exposes the FSM state (00 RUN, 01 STALL, 10 FLUSH) for observation.
module pipe_ctrl #(
  parameter int          FLUSH_LEN  = 2,
  parameter int          WDT_LIMIT  = 255,
  parameter logic [31:0] WDT_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        flush_req_i,
  input  logic [31:0] new_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic        wdt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t     state;
  logic [3:0] flush_cnt;
  logic       any_req;
  logic       stalled;
  logic       wdt_trip;

  assign any_req = stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
  assign stalled = (stall_o != 6'b000000);
  assign flush_o = (state == FLUSH);
  assign state_o = state;

  // Stall vector: the latest-stage request wins, since it freezes everything upstream.
  always_comb begin
    stall_o = 6'b000000;
    if (state != FLUSH) begin
      if (stallreq_mem_i)     stall_o = 6'b011111;
      else if (stallreq_ex_i) stall_o = 6'b001111;
      else if (stallreq_id_i) stall_o = 6'b000111;
      else if (stallreq_if_i) stall_o = 6'b000011;
      else                    stall_o = 6'b000000;
    end
  end

`ifdef STALL_WDT_EN
  logic [7:0] wdt_cnt;

  // The watchdog trips on the edge that closes the WDT_LIMIT-th consecutive stalled cycle.
  assign wdt_trip = stalled && (wdt_cnt == 8'(WDT_LIMIT - 1));

  // Consecutive-stall counter: saturating, cleared by any non-stalled cycle,
  // by a trip, or by a flush request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= 8'd0;
      wdt_o   <= 1'b0;
    end else begin
      wdt_o <= wdt_trip;
      if (wdt_trip || flush_req_i || !stalled) begin
        wdt_cnt <= 8'd0;
      end else if (wdt_cnt != 8'hFF) begin
        wdt_cnt <= wdt_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_wdt;

  assign wdt_trip   = 1'b0;
  assign wdt_o      = 1'b0;
  assign unused_wdt = ^{WDT_VECTOR, WDT_LIMIT[7:0]};
`endif

  // Control FSM. An external flush request outranks the watchdog, and both outrank stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      new_pc_o  <= 32'd0;
    end else if (flush_req_i) begin
      state     <= FLUSH;
      flush_cnt <= 4'(FLUSH_LEN - 1);
      new_pc_o  <= new_pc_i;
    end else if (wdt_trip) begin
      state     <= FLUSH;
      flush_cnt <= 4'(FLUSH_LEN - 1);
      new_pc_o  <= WDT_VECTOR;
    end else begin
      unique case (state)
        RUN: begin
          if (any_req) state <= STALL;
        end
        STALL: begin
          if (!any_req) state <= RUN;
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= any_req ? STALL : RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Performance counter of cycles with a non-zero stall vector; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= 32'd0;
    end else if (stalled) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with FLUSH_LEN=2 and WDT_LIMIT=4.
// Each cycle pushes the hand-derived expected outputs and drives the inputs.
// The expected entry is popped and compared on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        flush_req_i;
  logic [31:0] new_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles_o;
  logic        wdt_o;

  // expected entry: {state, stall, flush, new_pc, stall_cycles, wdt}
  logic [73:0] exp_q[$];
  int          checks;
  int          errors;
  int          cyc_n;

  pipe_ctrl #(
    .FLUSH_LEN (2),
    .WDT_LIMIT (4),
    .WDT_VECTOR(32'h0000_0180)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if_i (stallreq_if_i),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .flush_req_i   (flush_req_i),
    .new_pc_i      (new_pc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .state_o       (state_o),
    .stall_cycles_o(stall_cycles_o),
    .wdt_o         (wdt_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc_n, obs, exp);
    end
  endtask

  // One clock cycle. req = {mem, ex, id, if}.
  // The expectations describe the outputs seen during this cycle.
  task automatic cycle(input logic r, input logic [3:0] req, input logic fr,
                       input logic [31:0] pc, input logic [1:0] e_state,
                       input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic [31:0] e_cyc,
                       input logic e_wdt);
    logic [73:0] e;
    rst = r;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
    flush_req_i = fr;
    new_pc_i    = pc;
    exp_q.push_back({e_state, e_stall, e_flush, e_pc, e_cyc, e_wdt});
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("state",        {30'd0, state_o}, {30'd0, e[73:72]});
    check_val("stall",        {26'd0, stall_o}, {26'd0, e[71:66]});
    check_val("flush",        {31'd0, flush_o}, {31'd0, e[65]});
    check_val("new_pc",       new_pc_o,         e[64:33]);
    check_val("stall_cycles", stall_cycles_o,   e[32:1]);
    check_val("wdt",          {31'd0, wdt_o},   {31'd0, e[0]});
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc_n  = 0;
    rst = 1'b1;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = 4'b0000;
    flush_req_i = 1'b0;
    new_pc_i    = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // reset values, idle
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h0, 32'd0, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h0, 32'd0, 0);
    // id + mem for three cycles: mem wins
    cycle(0, 4'b1010, 0, 32'h0, 2'b00, 6'b011111, 0, 32'h0, 32'd0, 0);
    cycle(0, 4'b1010, 0, 32'h0, 2'b01, 6'b011111, 0, 32'h0, 32'd1, 0);
    cycle(0, 4'b1010, 0, 32'h0, 2'b01, 6'b011111, 0, 32'h0, 32'd2, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b01, 6'b000000, 0, 32'h0, 32'd3, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h0, 32'd3, 0);
    // flush pulse while ex stalls
    cycle(0, 4'b0100, 1, 32'h2000, 2'b00, 6'b001111, 0, 32'h0,    32'd3, 0);
    cycle(0, 4'b0100, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h2000, 32'd4, 0);
    cycle(0, 4'b0100, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h2000, 32'd4, 0);
    cycle(0, 4'b0100, 0, 32'h0,    2'b01, 6'b001111, 0, 32'h2000, 32'd4, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b01, 6'b000000, 0, 32'h2000, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b00, 6'b000000, 0, 32'h2000, 32'd5, 0);
    // second flush request during the first flush cycle restarts it
    cycle(0, 4'b0000, 1, 32'h2000, 2'b00, 6'b000000, 0, 32'h2000, 32'd5, 0);
    cycle(0, 4'b0000, 1, 32'h3000, 2'b10, 6'b000000, 1, 32'h2000, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h3000, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h3000, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b00, 6'b000000, 0, 32'h3000, 32'd5, 0);
    // remaining priority patterns
    cycle(0, 4'b0001, 0, 32'h0, 2'b00, 6'b000011, 0, 32'h3000, 32'd5, 0);
    cycle(0, 4'b0010, 0, 32'h0, 2'b01, 6'b000111, 0, 32'h3000, 32'd6, 0);
    cycle(0, 4'b0101, 0, 32'h0, 2'b01, 6'b001111, 0, 32'h3000, 32'd7, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b01, 6'b000000, 0, 32'h3000, 32'd8, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h3000, 32'd8, 0);
    // reset during FLUSH
    cycle(0, 4'b0000, 1, 32'h4000, 2'b00, 6'b000000, 0, 32'h3000, 32'd8, 0);
    cycle(1, 4'b0000, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h4000, 32'd8, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b00, 6'b000000, 0, 32'h0,    32'd0, 0);
    // reset during STALL
    cycle(0, 4'b1000, 0, 32'h0, 2'b00, 6'b011111, 0, 32'h0, 32'd0, 0);
    cycle(1, 4'b1000, 0, 32'h0, 2'b01, 6'b011111, 0, 32'h0, 32'd1, 0);
    cycle(0, 4'b1000, 0, 32'h0, 2'b00, 6'b011111, 0, 32'h0, 32'd0, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b01, 6'b000000, 0, 32'h0, 32'd1, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h0, 32'd1, 0);
`ifdef STALL_WDT_EN
    // watchdog: fetch stall held high, trips on the 4th stalled cycle
    cycle(0, 4'b0001, 0, 32'h0, 2'b00, 6'b000011, 0, 32'h0,   32'd1, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0,   32'd2, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0,   32'd3, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0,   32'd4, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b10, 6'b000000, 1, 32'h180, 32'd5, 1);
    cycle(0, 4'b0001, 0, 32'h0, 2'b10, 6'b000000, 1, 32'h180, 32'd5, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h180, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b01, 6'b000000, 0, 32'h180, 32'd6, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h180, 32'd6, 0);
    // flush request coinciding with a watchdog trip: request target wins, wdt still pulses
    cycle(0, 4'b0001, 0, 32'h0,    2'b00, 6'b000011, 0, 32'h180,  32'd6,  0);
    cycle(0, 4'b0001, 0, 32'h0,    2'b01, 6'b000011, 0, 32'h180,  32'd7,  0);
    cycle(0, 4'b0001, 0, 32'h0,    2'b01, 6'b000011, 0, 32'h180,  32'd8,  0);
    cycle(0, 4'b0001, 1, 32'h5000, 2'b01, 6'b000011, 0, 32'h180,  32'd9,  0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h5000, 32'd10, 1);
    cycle(0, 4'b0000, 0, 32'h0,    2'b10, 6'b000000, 1, 32'h5000, 32'd10, 0);
    cycle(0, 4'b0000, 0, 32'h0,    2'b00, 6'b000000, 0, 32'h5000, 32'd10, 0);
`else
    // no watchdog: a long stall never trips and never flushes
    cycle(0, 4'b0001, 0, 32'h0, 2'b00, 6'b000011, 0, 32'h0, 32'd1, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0, 32'd2, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0, 32'd3, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0, 32'd4, 0);
    cycle(0, 4'b0001, 0, 32'h0, 2'b01, 6'b000011, 0, 32'h0, 32'd5, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b01, 6'b000000, 0, 32'h0, 32'd6, 0);
    cycle(0, 4'b0000, 0, 32'h0, 2'b00, 6'b000000, 0, 32'h0, 32'd6, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
